// File: rtl/cmp_pkg.sv
// Shared definitions for the sequential comparator.
//   - Mode encoding for the per-operation is_signed input.
//   - FSM state encoding.
//   - Flag bundle, packed in {n, z, v, c} order.
package cmp_pkg;

   localparam logic CMP_UNSIGNED = 1'b0;
   localparam logic CMP_SIGNED   = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
      logic c;
   } flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Ripple-carry adder for one DIGIT-bit chunk.
// Ports:
//   x, y     in   DIGIT  addend chunks
//   cin      in   1      carry into bit 0
//   sum      out  DIGIT  x + y + cin, modulo 2^DIGIT
//   cout     out  1      carry out of the top bit
//   cin_msb  out  1      carry into the top bit (feeds signed-overflow detection)
module chunk_adder #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             cin_msb
);

   logic [DIGIT:0] carry;

   always_comb begin
      sum      = '0;
      carry    = '0;
      carry[0] = cin;
      for (int i = 0; i < DIGIT; i++) begin
         sum[i]       = x[i] ^ y[i] ^ carry[i];
         carry[i+1]   = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
      end
   end

   assign cout    = carry[DIGIT];
   assign cin_msb = carry[DIGIT-1];

endmodule

// File: rtl/seq_compare.sv
// Multi-cycle comparator: computes a - b as a + ~b + 1, DIGIT bits per cycle,
// LSB chunk first, then reports NZVC flags and decoded lt/eq/gt.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      request a compare (accepted only while ready)
//   is_signed  in   1      1 = two's-complement compare; sampled with start
//   a, b       in   WIDTH  minuend / subtrahend; sampled with start
//   ready      out  1      idle, able to accept start
//   done       out  1      one-cycle pulse, results valid
//   diff       out  WIDTH  a - b modulo 2^WIDTH
//   n, z, v, c out  1      negative, zero, signed overflow, carry (1 = no borrow)
//   lt, eq, gt out  1      decoded relation for the latched mode
module seq_compare
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             n,
   output logic             z,
   output logic             v,
   output logic             c,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int unsigned NCHUNK = WIDTH / DIGIT;
   localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] nb_q, nb_d;   // ~b, latched at start
   logic             mode_q, mode_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   flags_t           flags_q, flags_d;
   logic             lt_q, lt_d;
   logic             eq_q, eq_d;
   logic             gt_q, gt_d;
   logic             done_q, done_d;

   int unsigned      base;
   logic [DIGIT-1:0] a_chunk, b_chunk, sum;
   logic             cout, cin_msb, last;

   always_comb begin
      base    = 32'(k_q) * DIGIT;
      a_chunk = a_q[base +: DIGIT];
      b_chunk = nb_q[base +: DIGIT];
      last    = (k_q == KW'(NCHUNK - 1));
   end

   chunk_adder #(
      .DIGIT(DIGIT)
   ) u_chunk_adder (
      .x      (a_chunk),
      .y      (b_chunk),
      .cin    (carry_q),
      .sum    (sum),
      .cout   (cout),
      .cin_msb(cin_msb)
   );

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      nb_d    = nb_q;
      mode_d  = mode_q;
      carry_d = carry_q;
      diff_d  = diff_q;
      flags_d = flags_q;
      lt_d    = lt_q;
      eq_d    = eq_q;
      gt_d    = gt_q;
      done_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               nb_d    = ~b;
               mode_d  = is_signed;
               carry_d = 1'b1;
               k_d     = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            diff_d[base +: DIGIT] = sum;
            carry_d = cout;
            k_d     = k_q + KW'(1);
            if (last) begin
               // The top chunk's adder sees bit WIDTH-1, so its cin_msb is the
               // carry into the operand MSB.
               flags_d.n = diff_d[WIDTH-1];
               flags_d.z = ~|diff_d;
               flags_d.c = cout;
               flags_d.v = cin_msb ^ cout;
               lt_d      = (mode_q == CMP_SIGNED) ? (flags_d.n ^ flags_d.v) : ~cout;
               eq_d      = flags_d.z;
               gt_d      = ~lt_d & ~flags_d.z;
               k_d       = '0;
               done_d    = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         nb_q    <= '0;
         mode_q  <= CMP_UNSIGNED;
         carry_q <= 1'b1;
         diff_q  <= '0;
         flags_q <= '0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         nb_q    <= nb_d;
         mode_q  <= mode_d;
         carry_q <= carry_d;
         diff_q  <= diff_d;
         flags_q <= flags_d;
         lt_q    <= lt_d;
         eq_q    <= eq_d;
         gt_q    <= gt_d;
         done_q  <= done_d;
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = done_q;
   assign diff  = diff_q;
   assign n     = flags_q.n;
   assign z     = flags_q.z;
   assign v     = flags_q.v;
   assign c     = flags_q.c;
   assign lt    = lt_q;
   assign eq    = eq_q;
   assign gt    = gt_q;

endmodule

// File: tb/tb_seq_compare.sv
// Directed bench for seq_compare: main instance WIDTH=8/DIGIT=2, plus DIGIT=8
// and DIGIT=1 instances for the latency corners. Inputs change and outputs are
// sampled on the falling edge.
module tb_seq_compare;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, start8 = 1'b0, start1 = 1'b0;
   logic is_signed = 1'b0;
   logic [7:0] a = 8'h00, b = 8'h00;

   logic       ready, done, n, z, v, c, lt, eq, gt;
   logic [7:0] diff;
   logic       ready8, done8, n8, z8, v8, c8, lt8, eq8, gt8;
   logic [7:0] diff8;
   logic       ready1, done1, n1, z1, v1, c1, lt1, eq1, gt1;
   logic [7:0] diff1;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seq_compare #(.WIDTH(8), .DIGIT(2)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
      .ready(ready), .done(done), .diff(diff), .n(n), .z(z), .v(v), .c(c),
      .lt(lt), .eq(eq), .gt(gt)
   );

   seq_compare #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .is_signed(is_signed), .a(a), .b(b),
      .ready(ready8), .done(done8), .diff(diff8), .n(n8), .z(z8), .v(v8), .c(c8),
      .lt(lt8), .eq(eq8), .gt(gt8)
   );

   seq_compare #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .is_signed(is_signed), .a(a), .b(b),
      .ready(ready1), .done(done1), .diff(diff1), .n(n1), .z(z1), .v(v1), .c(c1),
      .lt(lt1), .eq(eq1), .gt(gt1)
   );

   // Result vectors: {diff, n, z, v, c, lt, eq, gt}
   wire [14:0] res  = {diff, n, z, v, c, lt, eq, gt};
   wire [14:0] res8 = {diff8, n8, z8, v8, c8, lt8, eq8, gt8};
   wire [14:0] res1 = {diff1, n1, z1, v1, c1, lt1, eq1, gt1};

   localparam logic [14:0] R_SOVF  = {8'hFF, 7'b1010_001};
   localparam logic [14:0] R_UOVF  = {8'hFF, 7'b1010_100};
   localparam logic [14:0] R_EQ    = {8'h00, 7'b0101_010};
   localparam logic [14:0] R_SMALL = {8'hFE, 7'b1000_100};

   // Drive operands at a falling edge; the next rising edge is E0.
   task automatic issue(input int sel, input logic [7:0] av, input logic [7:0] bv,
                        input logic sv);
      a = av;
      b = bv;
      is_signed = sv;
      if (sel == 0) start = 1'b1;
      else if (sel == 1) start8 = 1'b1;
      else start1 = 1'b1;
   endtask

   // Returns edges from E0 until done is seen (-1 if the bound expires).
   task automatic wait_done(input int sel, output int lat);
      logic d;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         start8 = 1'b0;
         start1 = 1'b0;
         d = (sel == 0) ? done : (sel == 1) ? done8 : done1;
         if (d) begin
            lat = i - 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if (res !== 15'h0 || ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got res=%h ready=%b done=%b, want res=0000 ready=1 done=0",
                  res, ready, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_op(input string name, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [14:0] want);
      int lat;
      issue(0, av, bv, sv);
      wait_done(0, lat);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL %s_latency: got %0d, want 4", name, lat);
      end
      total++;
      if (res !== want) begin
         bad++;
         $display("FAIL %s_result: got %h, want %h", name, res, want);
      end
   endtask

   task automatic test_ignored_start;
      int lat;
      issue(0, 8'h7F, 8'h80, 1'b1);
      @(negedge clk);             // after E0
      start = 1'b0;
      @(negedge clk);             // after E1; next edge is E2
      total++;
      if (ready !== 1'b0) begin
         bad++;
         $display("FAIL busy_ready: got %b, want 0", ready);
      end
      issue(0, 8'h03, 8'h05, 1'b0);
      wait_done(0, lat);          // lat counted from E2 here
      total++;
      if (lat !== 2) begin
         bad++;
         $display("FAIL ignored_start_latency: got %0d edges after E2, want 2", lat);
      end
      total++;
      if (res !== R_SOVF) begin
         bad++;
         $display("FAIL ignored_start_result: got %h, want %h", res, R_SOVF);
      end
      // An ignored start must not have been queued.
      repeat (6) begin
         @(negedge clk);
         if (done) begin
            total++;
            bad++;
            $display("FAIL ignored_start_queued: got done=1, want 0");
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat;
      issue(0, 8'h5A, 8'h5A, 1'b0);
      wait_done(0, lat);
      total++;
      if (res !== R_EQ || lat !== 4) begin
         bad++;
         $display("FAIL b2b_first: got res=%h lat=%0d, want res=%h lat=4", res, lat, R_EQ);
      end
      total++;
      if (ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready_in_done: got %b, want 1", ready);
      end
      issue(0, 8'h03, 8'h05, 1'b0);   // during the done cycle
      wait_done(0, lat);
      total++;
      if (lat !== 4) begin
         bad++;
         $display("FAIL b2b_second_latency: got %0d, want 4", lat);
      end
      total++;
      if (res !== R_SMALL) begin
         bad++;
         $display("FAIL b2b_second_result: got %h, want %h", res, R_SMALL);
      end
   endtask

   task automatic test_reset_mid;
      int dones = 0;
      issue(0, 8'h7F, 8'h80, 1'b1);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;                 // sampled at E2
      @(negedge clk);
      total++;
      if (res !== 15'h0 || ready !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_state: got res=%h ready=%b done=%b, want 0000/1/0",
                  res, ready, done);
      end
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (done) dones++;
      end
      total++;
      if (dones !== 0) begin
         bad++;
         $display("FAIL reset_mid_no_done: got %0d dones, want 0", dones);
      end
   endtask

   task automatic test_digit_corners;
      int lat;
      issue(1, 8'h7F, 8'h80, 1'b1);
      wait_done(1, lat);
      total++;
      if (lat !== 1 || res8 !== R_SOVF) begin
         bad++;
         $display("FAIL digit8: got lat=%0d res=%h, want lat=1 res=%h", lat, res8, R_SOVF);
      end
      issue(2, 8'h7F, 8'h80, 1'b1);
      wait_done(2, lat);
      total++;
      if (lat !== 8 || res1 !== R_SOVF) begin
         bad++;
         $display("FAIL digit1: got lat=%0d res=%h, want lat=8 res=%h", lat, res1, R_SOVF);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_op("signed_ovf",   8'h7F, 8'h80, 1'b1, R_SOVF);
      test_op("unsigned_ovf", 8'h7F, 8'h80, 1'b0, R_UOVF);
      test_op("eq_signed",    8'h5A, 8'h5A, 1'b1, R_EQ);
      test_op("eq_unsigned",  8'h5A, 8'h5A, 1'b0, R_EQ);
      test_op("small_uns",    8'h03, 8'h05, 1'b0, R_SMALL);
      test_ignored_start();
      test_back_to_back();
      test_reset_mid();
      test_digit_corners();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
